// File: rtl/pc_gen.sv
// RV32I front-end program-counter generator: fetch handshake, redirect/trap, sequential advance.
// Define PC_RAS_EN to add a circular return-address stack driven by predecode call/return hints.
module pc_gen #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 32'h0000_0100,
  parameter int              RAS_DEPTH    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  output logic            pc_valid,
  input  logic            pc_ready,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  input  logic            redirect,
  input  logic            redirect_jalr,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm,
  input  logic [XLEN-1:0] ex_rs1,
  input  logic            pred_call,
  input  logic            pred_ret,
  input  logic [XLEN-1:0] pred_imm,
  output logic            trap,
  output logic [XLEN-1:0] trap_tval
);

  logic [XLEN-1:0] pc_q, pc_d;
  logic            vld_q, vld_d;
  logic            trap_q, trap_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic [XLEN-1:0] tgt;
  logic [XLEN-1:0] adv_pc;
  logic            fire;

  assign fire = vld_q & pc_ready & ~stall;
  assign pc_4 = pc_q + {{(XLEN-3){1'b0}}, 3'd4};

  // JALR clears bit 0 before the alignment check, so only bit 1 can trap there.
  assign tgt = redirect_jalr ? ((ex_rs1 + ex_imm) & {{(XLEN-1){1'b1}}, 1'b0})
                             : (ex_pc + ex_imm);

`ifdef PC_RAS_EN
  localparam int PW = $clog2(RAS_DEPTH);

  logic [XLEN-1:0] ras_q [RAS_DEPTH];
  logic [XLEN-1:0] ras_d [RAS_DEPTH];
  logic [PW-1:0]   ptr_q, ptr_d, top_idx;
  logic [PW:0]     cnt_q, cnt_d;

  // ptr_q is the next free slot; the top of stack sits one below it.
  always_comb begin
    ras_d   = ras_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    top_idx = ptr_q - 1'b1;
    adv_pc  = pc_4;
    if (fire && !redirect) begin
      if (pred_call && pred_ret) begin
        if (cnt_q != '0) begin
          adv_pc         = ras_q[top_idx];
          ras_d[top_idx] = pc_4;
        end else begin
          ras_d[ptr_q] = pc_4;
          ptr_d        = ptr_q + 1'b1;
          cnt_d        = {{PW{1'b0}}, 1'b1};
        end
      end else if (pred_call) begin
        adv_pc       = pc_q + pred_imm;
        ras_d[ptr_q] = pc_4;
        ptr_d        = ptr_q + 1'b1;
        if (cnt_q != (PW+1)'(RAS_DEPTH)) cnt_d = cnt_q + 1'b1;
      end else if (pred_ret && cnt_q != '0) begin
        adv_pc = ras_q[top_idx];
        ptr_d  = top_idx;
        cnt_d  = cnt_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entries are only ever read below cnt_q, so they need no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= ras_d[i];
  end
`else
  logic unused_hints;
  assign unused_hints = ^{pred_call, pred_ret, pred_imm};
  assign adv_pc       = pc_4;
`endif

  always_comb begin
    pc_d   = pc_q;
    vld_d  = 1'b1;
    trap_d = 1'b0;
    tval_d = tval_q;
    if (redirect) begin
      if (tgt[1:0] != 2'b00) begin
        pc_d   = TRAP_VECTOR;
        trap_d = 1'b1;
        tval_d = tgt;
      end else begin
        pc_d = tgt;
      end
    end else if (fire) begin
      pc_d = adv_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc_q   <= RESET_VECTOR;
      vld_q  <= 1'b0;
      trap_q <= 1'b0;
      tval_q <= '0;
    end else begin
      pc_q   <= pc_d;
      vld_q  <= vld_d;
      trap_q <= trap_d;
      tval_q <= tval_d;
    end
  end

  assign pc        = pc_q;
  assign pc_valid  = vld_q;
  assign trap      = trap_q;
  assign trap_tval = tval_q;

endmodule

// File: tb/tb_pc_gen.sv
// Scoreboard bench for pc_gen: driver queues expected outputs per cycle, monitor pops on the falling edge.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rstn, pc_ready, stall, redirect, redirect_jalr;
  logic        pred_call, pred_ret;
  logic [31:0] ex_pc, ex_imm, ex_rs1, pred_imm;
  logic        pc_valid, trap;
  logic [31:0] pc, pc_4, trap_tval;

  typedef struct {
    logic        vld;
    logic [31:0] pc;
    logic        trap;
    logic [31:0] tval;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rstn(rstn), .pc_valid(pc_valid), .pc_ready(pc_ready), .stall(stall),
    .pc(pc), .pc_4(pc_4), .redirect(redirect), .redirect_jalr(redirect_jalr),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .pred_call(pred_call),
    .pred_ret(pred_ret), .pred_imm(pred_imm), .trap(trap), .trap_tval(trap_tval)
  );

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", n, act, exp, $time);
    end
  endtask

  // Monitor: outputs settled since the last rising edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("pc_valid", {31'b0, pc_valid}, {31'b0, e.vld});
      chk("pc", pc, e.pc);
      chk("pc_4", pc_4, e.pc + 32'd4);
      chk("trap", {31'b0, trap}, {31'b0, e.trap});
      chk("trap_tval", trap_tval, e.tval);
    end
  end

  // Queue the outputs expected after the next rising edge, then take that edge.
  task automatic go(input logic v, input logic [31:0] p, input logic t, input logic [31:0] tv);
    exp_t e;
    e.vld = v; e.pc = p; e.trap = t; e.tval = tv;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic redir(input logic j, input logic [31:0] epc, input logic [31:0] imm,
                       input logic [31:0] rs1);
    redirect = 1'b1; redirect_jalr = j; ex_pc = epc; ex_imm = imm; ex_rs1 = rs1;
  endtask

  initial begin
    rstn = 1'b0; pc_ready = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_jalr = 1'b0;
    ex_pc = '0; ex_imm = '0; ex_rs1 = '0; pred_call = 1'b0; pred_ret = 1'b0; pred_imm = '0;

    go(0, 32'h0, 0, 32'h0);
    go(0, 32'h0, 0, 32'h0);
    rstn = 1'b1;
    go(1, 32'h0, 0, 32'h0);
    go(1, 32'h4, 0, 32'h0);
    go(1, 32'h8, 0, 32'h0);
    go(1, 32'hC, 0, 32'h0);
    go(1, 32'h10, 0, 32'h0);

    stall = 1'b1;
    repeat (3) go(1, 32'h10, 0, 32'h0);
    stall = 1'b0; pc_ready = 1'b0;
    repeat (2) go(1, 32'h10, 0, 32'h0);
    pc_ready = 1'b1;
    go(1, 32'h14, 0, 32'h0);

    // Redirects proceed despite stall.
    stall = 1'b1;
    redir(0, 32'h40, 32'hFFFF_FFF0, 32'h0);
    go(1, 32'h30, 0, 32'h0);
    redir(1, 32'h0, 32'h4, 32'h101);
    go(1, 32'h104, 0, 32'h0);
    redir(0, 32'h40, 32'h2, 32'h0);
    go(1, 32'h100, 1, 32'h42);
    redirect = 1'b0;
    go(1, 32'h100, 0, 32'h42);
    stall = 1'b0;
    go(1, 32'h104, 0, 32'h42);

    redir(0, 32'h0, 32'hFFFF_FFFC, 32'h0);
    go(1, 32'hFFFF_FFFC, 0, 32'h42);
    redirect = 1'b0;
    go(1, 32'h0, 0, 32'h42);
    go(1, 32'h4, 0, 32'h42);

    rstn = 1'b0;
    redir(0, 32'h40, 32'h20, 32'h0);
    go(0, 32'h0, 0, 32'h0);
    rstn = 1'b1; redirect = 1'b0;
    go(1, 32'h0, 0, 32'h0);
    go(1, 32'h4, 0, 32'h0);

    redir(0, 32'h20, 32'h0, 32'h0);
    go(1, 32'h20, 0, 32'h0);
    redirect = 1'b0; pred_call = 1'b1; pred_imm = 32'h80;
`ifdef PC_RAS_EN
    go(1, 32'hA0, 0, 32'h0);
    pred_call = 1'b0;
    redir(0, 32'h100, 32'h0, 32'h0);
    go(1, 32'h100, 0, 32'h0);
    redirect = 1'b0; pred_call = 1'b1; pred_imm = 32'h100;
    go(1, 32'h200, 0, 32'h0);
    go(1, 32'h300, 0, 32'h0);
    go(1, 32'h400, 0, 32'h0);
    go(1, 32'h500, 0, 32'h0);
    go(1, 32'h600, 0, 32'h0);
    pred_call = 1'b0; pred_ret = 1'b1;
    go(1, 32'h504, 0, 32'h0);
    go(1, 32'h404, 0, 32'h0);
    go(1, 32'h304, 0, 32'h0);
    go(1, 32'h204, 0, 32'h0);
    go(1, 32'h208, 0, 32'h0);
    pred_call = 1'b1;
    go(1, 32'h20C, 0, 32'h0);
    pred_call = 1'b0;
    go(1, 32'h20C, 0, 32'h0);
    go(1, 32'h210, 0, 32'h0);
    pred_ret = 1'b0;
`else
    go(1, 32'h24, 0, 32'h0);
    pred_call = 1'b0; pred_ret = 1'b1;
    go(1, 32'h28, 0, 32'h0);
    pred_ret = 1'b0;
`endif

    repeat (3) @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
